// File: rtl/alu_exerciser_pkg.sv
// Shared types and constants for the ALU self-test exerciser.
// FSM encoding, ALU function codes and the last vector index.
package alu_exerciser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  localparam logic [9:0] VEC_LAST = 10'd1023;

endpackage

// File: rtl/alu_ref_model.sv
// Golden model of the 4-bit add/sub/xor ALU.
// Purely combinational; result is mod 16.
module alu_ref_model
  import alu_exerciser_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [1:0] f,
  output logic [3:0] exp_res
);

  always_comb begin
    exp_res = '0;
    unique case (f)
      OP_ADD:  exp_res = x + y;
      OP_SUB:  exp_res = x + ~y + 4'd1;
      OP_XOR:  exp_res = x ^ y;
      OP_XNOR: exp_res = x ^ ~y;
      default: exp_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_exerciser.sv
// Sweeps all 1024 operand/function vectors through the ALU
// and checks the synchronised result against the golden model.
module alu_exerciser
  import alu_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           res,
  output logic [3:0]           op_x,
  output logic [3:0]           op_y,
  output logic [1:0]           op_f,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 fail_valid,
  output logic [9:0]           fail_idx,
  output logic [3:0]           fail_got
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t                 state;
  logic [9:0]             idx;
  logic [CNT_W-1:0]       cnt;
  logic [3:0]             res_q1;
  logic [3:0]             res_s;
  logic [3:0]             golden;
  logic                   mismatch;
  logic                   running;
  logic [ERR_CNT_W-1:0]   err_nxt;

  alu_ref_model u_ref (
    .x       (op_x),
    .y       (op_y),
    .f       (op_f),
    .exp_res (golden)
  );

  // res is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q1 <= '0;
      res_s  <= '0;
    end else begin
      res_q1 <= res;
      res_s  <= res_q1;
    end
  end

  assign running  = (state == S_DRIVE) || (state == S_SETTLE) ||
                    (state == S_CHECK);
  assign mismatch = (res_s != golden);
  assign err_nxt  = (mismatch && (err_cnt != '1)) ?
                    err_cnt + 1'b1 : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      op_x       <= '0;
      op_y       <= '0;
      op_f       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      fail_got   <= '0;
    end else if (abort && running) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      op_x  <= '0;
      op_y  <= '0;
      op_f  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_DRIVE;
            idx        <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            fail_got   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_DRIVE: begin
          op_x  <= idx[3:0];
          op_y  <= idx[7:4];
          op_f  <= idx[9:8];
          cnt   <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_cnt <= err_nxt;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
              fail_got   <= res_s;
            end
          end
          if (idx == VEC_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
            op_x  <= '0;
            op_y  <= '0;
            op_f  <= '0;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
